// File: rtl/i2c_mem_master.sv
// rtl/i2c_mem_master.sv - two-requester round-robin I2C master for single-byte memory reads/writes
// Optional clock stretching on SCL is enabled by defining I2C_MEM_MASTER_STRETCH_EN.
module i2c_mem_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] rw,
   input  logic [6:0] addr0,
   input  logic [6:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic [1:0] gnt,
   output logic       done,
   output logic       nack,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       scl_oe,
   input  logic       scl_in,
   output logic       sda_oe,
   input  logic       sda_in
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_AACK,
      S_DATA,
      S_DACK,
      S_STOP,
      S_DONE
   } state_t;

   localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic       ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] shift_q, shift_d;
   logic       flag_q, flag_d;
   logic [1:0] gnt_q, gnt_d;
   logic       done_q, done_d;
   logic       nack_q, nack_d;
   logic [7:0] rdata_q, rdata_d;
   logic       busy_q, busy_d;
   logic       scl_oe_q, scl_oe_d;
   logic       sda_oe_q, sda_oe_d;

   logic       adv;
   logic       last_cyc;
   logic       bit_end;
   logic       sample;
   logic       pick;
   logic [7:0] abyte;

`ifdef I2C_MEM_MASTER_STRETCH_EN
   // A slave holding SCL low freezes the bit timing in quarter 2.
   assign adv = !(qtr_q == 2'd2 && !scl_in);
`else
   logic unused_scl;
   assign unused_scl = scl_in;
   assign adv = 1'b1;
`endif

   assign last_cyc = (cnt_q == CNT_MAX);
   assign bit_end  = adv && last_cyc && (qtr_q == 2'd3);
   assign sample   = adv && (cnt_q == 8'd0) && (qtr_q == 2'd2);
   assign abyte    = {addr_q, rw_q};
   assign pick     = (req == 2'b11) ? ~ptr_q : req[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      ptr_d   = ptr_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      shift_d = shift_q;
      flag_d  = flag_q;
      gnt_d   = gnt_q;
      done_d  = 1'b0;
      nack_d  = nack_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;

      if (state_q != S_IDLE && state_q != S_DONE && adv) begin
         if (last_cyc) begin
            cnt_d = 8'd0;
            qtr_d = qtr_q + 2'd1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (gnt_q != 2'b00) begin
               state_d = S_START;
            end else if (req != 2'b00) begin
               gnt_d   = pick ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
               rw_d    = rw[pick];
               addr_d  = pick ? addr1 : addr0;
               wdata_d = pick ? wdata1 : wdata0;
               flag_d  = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_ADDR;
               bit_d   = 3'd7;
            end
         end
         S_ADDR: begin
            if (bit_end) begin
               if (bit_q == 3'd0) state_d = S_AACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         S_AACK: begin
            if (sample && sda_in) flag_d = 1'b1;
            if (bit_end) begin
               state_d = flag_q ? S_STOP : S_DATA;
               bit_d   = 3'd7;
            end
         end
         S_DATA: begin
            if (sample && rw_q) shift_d = {shift_q[6:0], sda_in};
            if (bit_end) begin
               if (bit_q == 3'd0) state_d = S_DACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         S_DACK: begin
            if (sample && !rw_q && sda_in) flag_d = 1'b1;
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               nack_d  = flag_q;
               if (rw_q && !flag_q) rdata_d = shift_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
            ptr_d   = gnt_q[1];
         end
         default: state_d = S_IDLE;
      endcase

      // Pin drives follow the next bit position so they line up with the counters.
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         S_START: begin
            scl_oe_d = (qtr_d < 2'd2);
            sda_oe_d = (qtr_d >= 2'd2);
         end
         S_ADDR: begin
            scl_oe_d = (qtr_d < 2'd2);
            sda_oe_d = ~abyte[bit_d];
         end
         S_AACK, S_DACK: begin
            scl_oe_d = (qtr_d < 2'd2);
         end
         S_DATA: begin
            scl_oe_d = (qtr_d < 2'd2);
            sda_oe_d = rw_q ? 1'b0 : ~wdata_q[bit_d];
         end
         S_STOP: begin
            scl_oe_d = (qtr_d < 2'd2);
            sda_oe_d = (qtr_d < 2'd2);
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         qtr_q    <= 2'd0;
         bit_q    <= 3'd0;
         ptr_q    <= 1'b1;
         rw_q     <= 1'b0;
         addr_q   <= 7'd0;
         wdata_q  <= 8'd0;
         shift_q  <= 8'd0;
         flag_q   <= 1'b0;
         gnt_q    <= 2'b00;
         done_q   <= 1'b0;
         nack_q   <= 1'b0;
         rdata_q  <= 8'd0;
         busy_q   <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         ptr_q    <= ptr_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         shift_q  <= shift_d;
         flag_q   <= flag_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         nack_q   <= nack_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign nack   = nack_q;
   assign rdata  = rdata_q;
   assign busy   = busy_q;
   assign scl_oe = scl_oe_q;
   assign sda_oe = sda_oe_q;

endmodule

// File: doc/i2c_mem_master.md
# i2c_mem_master

- Sequences single-byte read and write transactions on the two-wire bus to the 128-entry memory slave.
- Shares the bus between two local requesters using round-robin arbitration.
- Owns the bus: generates START, 7-bit word address plus R/W, data byte, both ACK slots, and STOP.
- Returns read data and ACK status to the granted requester.

## Interface

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-bit; one bit period = 4*CLK_DIV cycles; legal range 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- req  input  2  per-requester transaction request; held until its done.
- rw  input  2  per-requester direction: 1 = read, 0 = write.
- addr0, addr1  input  7 each  word address of requester 0 / 1.
- wdata0, wdata1  input  8 each  write data of requester 0 / 1.
- gnt  output  2  one-hot grant; held for the whole transaction.
- done  output  1  one-cycle pulse at transaction end; qualified by gnt.
- nack  output  1  valid with done; 1 = address or write-data slot not acknowledged.
- rdata  output  8  read byte; valid with done for reads; holds until the next read completes.
- busy  output  1  1 from the grant cycle through the done cycle.
- scl_oe  output  1  1 pulls SCL low; 0 releases it (open drain).
- scl_in  input  1  sampled SCL line.
- sda_oe  output  1  1 pulls SDA low; 0 releases it.
- sda_in  input  1  sampled SDA line.

## Operation

- States: IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE.
- **IDLE**:
  - With any req set, assert the grant next cycle.
  - If both requesters are active, grant the one not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - Capture rw, addr and wdata of the winner in the grant cycle. Later changes to those inputs are ignored.
- **START**, one bit period: SDA released in quarters 0–1 and pulled low in quarter 2 while SCL is high.
- **ADDR**, 8 bits, MSB first: {addr[6:0], rw}.
- **AACK**:
  - SDA is released.
  - sda_in sampled 0 → go to DATA.
  - sda_in sampled 1 → set the nack flag and go to STOP, skipping DATA and DACK.
- **DATA**, 8 bits, MSB first:
  - Write: drive wdata.
  - Read: release SDA and shift sda_in into the rdata shift register.
- **DACK**:
  - Write: release SDA and sample the slave ACK; 1 sets nack.
  - Read: the master releases SDA (NACK, end of read).
- **STOP**, one bit period: SDA held low in quarters 0–1 and released in quarter 2 while SCL is high.
- **DONE**, one cycle:
  - done = 1; nack = flag; rdata updated only when rw = 1 and nack = 0.
  - Next cycle: gnt = 0, busy = 0, state IDLE, pointer updated to the served requester.
- A requester dropping req mid-transaction does not abort it; the transaction completes normally.
- Bit counter is 3 bits, counting 7 down to 0; exit the state on 0.

## Timing

- Each bit is 4 quarters of CLK_DIV cycles.
  - SCL is low in quarters 0–1 and released in quarters 2–3.
  - SDA changes only at the start of quarter 0.
  - sda_in is sampled in the first cycle of quarter 2.
- Request latency: req seen in IDLE → gnt at next edge.
- Transaction length, measured from gnt to the done cycle:
  - Full: 20 bit periods, 80*CLK_DIV cycles, then +1 cycle.
  - Address NACK: 11 bit periods, 44*CLK_DIV cycles, then +1 cycle.
- Back-to-back: with req still high after done, the next grant occurs 1 cycle after gnt clears, so 2 cycles from done to the next gnt.
- Reset values, held while rst = 0 and applied immediately mid-transaction:
  - gnt = 0, done = 0, nack = 0, rdata = 0, busy = 0.
  - scl_oe = 0, sda_oe = 0, state IDLE, pointer = 1.
  - No STOP is generated on reset.

## Configuration

- I2C_MEM_MASTER_STRETCH_EN defined:
  - The quarter counter does not leave quarter 2 until scl_in = 1 (clock stretching).
  - Each stall cycle extends the transaction by one cycle.
- Undefined: scl_in is ignored; timing is exactly as above.

## Test plan

- CLK_DIV = 2, req = 01, rw0 = 0, addr0 = 7'h15, wdata0 = 8'hA5, slave ACKs both slots → SDA bit stream 0x2A then 0xA5; done at cycle 161 after gnt; nack = 0; model mem[0x15] = 0xA5.
- Then req = 01, rw0 = 1, addr0 = 7'h15, slave drives 0xA5 → byte 0x2B on the bus; done with rdata = 8'hA5, nack = 0; master releases SDA in DACK.
- req = 11 asserted together from reset → gnt = 01 first, then gnt = 10 two cycles after the first done; never both bits set.
- Address slot NACKed (sda_in = 1 in AACK) → STOP follows immediately; done at 44*CLK_DIV + 1 cycles with nack = 1; rdata unchanged.
- rst driven low mid-DATA → same cycle: scl_oe = 0, sda_oe = 0, gnt = 00, busy = 0; after release, a fresh req is granted normally.
- With I2C_MEM_MASTER_STRETCH_EN, scl_in forced 0 for 10 cycles at the third ADDR bit → done delayed by exactly 10 cycles; bit stream unchanged.
